uart_tx_ctrl: RTL and testbench

//  Sequencing FSM for the UART transmitter. Accepts a frame request, latches data/config and

---
 rtl/uart_tx_ctrl_pkg.sv | 30 +++
 rtl/uart_tx_bit_cnt.sv | 35 +++
 rtl/uart_tx_ctrl.sv | 122 ++++++++++++
 tb/tb_uart_tx_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_ctrl_pkg.sv
// uart_tx_ctrl_pkg
//   Shared definitions for the UART transmit path: FSM state encodings, frame-bit
//   mux select codes and the state-to-mux decode. The bit mux imports the same
//   package, so both sides agree on the select encoding.
package uart_tx_ctrl_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic [1:0] MUX_IDLE  = 2'b00; // line high (idle and stop bits)
  localparam logic [1:0] MUX_START = 2'b01; // start bit (0)
  localparam logic [1:0] MUX_DATA  = 2'b10; // data_q[bit_idx]
  localparam logic [1:0] MUX_PAR   = 2'b11; // registered parity result

  function automatic logic [1:0] mux_for_state(input logic [2:0] st);
    logic [1:0] sel;
    sel = MUX_IDLE;
    case (st)
      ST_START:  sel = MUX_START;
      ST_DATA:   sel = MUX_DATA;
      ST_PARITY: sel = MUX_PAR;
      default:   sel = MUX_IDLE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/uart_tx_bit_cnt.sv
// uart_tx_bit_cnt
//   Up-counter with synchronous clear and enable. Counts data bits while the
//   controller is in DATA and stop bits while it is in STOP; tc flags that the
//   count has reached the supplied terminal value.
// Ports
//   clk   in   baud clock
//   rst   in   synchronous active-high reset
//   clr   in   clear count to 0 (takes priority over en)
//   en    in   increment count
//   last  in   terminal value compared against the count
//   cnt   out  current count
//   tc    out  count == last
module uart_tx_bit_cnt #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [CW-1:0] last,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == last);

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl
//   Sequencing FSM for the UART transmitter. One clk per line bit. Accepts a
//   frame request, latches payload and parity config, and drives the parity
//   calculator enable, the frame-bit mux select and the data bit index.
//   Frame: START, DATA_WIDTH data bits LSB first, optional PARITY, STOP_BITS stop.
// Ports
//   clk         in   TX baud clock
//   rst         in   synchronous active-high reset
//   data_valid  in   frame request
//   p_data      in   payload, sampled on accept
//   par_en      in   parity bit present, sampled on accept
//   par_typ     in   0 even / 1 odd, sampled on accept
//   data_ack    out  1-cycle pulse for an accepted request
//   busy        out  frame in progress
//   data_q      out  latched payload
//   par_typ_q   out  latched parity type
//   par_calc_en out  parity calculator enable (START cycle)
//   mux_sel     out  frame-bit mux select
//   bit_idx     out  data bit currently selected
//   state_dbg   out  current FSM state (debug observation)
//
// Request handshake: a request is taken on a clk edge where data_valid=1 and the
// controller is ready (IDLE, or the last STOP cycle). data_ack is a registered
// one-cycle pulse in the cycle after that edge, which is also the first START
// cycle. A request seen while not ready is dropped, never queued.
//
// Every output is a register; the output registers are loaded from the next
// state so that they line up with the state register.
module uart_tx_ctrl
  import uart_tx_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1,
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_valid,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  data_ack,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] data_q,
  output logic                  par_typ_q,
  output logic                  par_calc_en,
  output logic [1:0]            mux_sel,
  output logic [IW-1:0]         bit_idx,
  output logic [2:0]            state_dbg
);

  logic [2:0]    state_q;
  logic [2:0]    state_d;
  logic          par_en_q;
  logic          accept;
  logic          cnt_clr;
  logic          cnt_en;
  logic [IW-1:0] cnt_last;
  logic [IW-1:0] cnt;
  logic          cnt_tc;

  // One counter serves both DATA and STOP; it restarts on every state change.
  assign cnt_clr  = (state_d != state_q);
  assign cnt_en   = (state_q == ST_DATA) || (state_q == ST_STOP);
  assign cnt_last = (state_q == ST_DATA) ? IW'(DATA_WIDTH - 1) : IW'(STOP_BITS - 1);

  uart_tx_bit_cnt #(.CW(IW)) u_bit_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .last (cnt_last),
    .cnt  (cnt),
    .tc   (cnt_tc)
  );

  always_comb begin
    accept  = data_valid &&
              ((state_q == ST_IDLE) || ((state_q == ST_STOP) && cnt_tc));
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_START;
      ST_START:  state_d = ST_DATA;
      ST_DATA:   if (cnt_tc) state_d = par_en_q ? ST_PARITY : ST_STOP;
      ST_PARITY: state_d = ST_STOP;
      ST_STOP:   if (cnt_tc) state_d = accept ? ST_START : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      busy        <= 1'b0;
      data_ack    <= 1'b0;
      par_calc_en <= 1'b0;
      mux_sel     <= MUX_IDLE;
      bit_idx     <= '0;
      data_q      <= '0;
      par_en_q    <= 1'b0;
      par_typ_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy        <= (state_d != ST_IDLE);
      data_ack    <= accept;
      par_calc_en <= (state_d == ST_START);
      mux_sel     <= mux_for_state(state_d);
      if (accept) begin
        data_q    <= p_data;
        par_en_q  <= par_en;
        par_typ_q <= par_typ;
      end
      // Restart at 0 on entry to DATA, step while in DATA, hold elsewhere.
      if (state_d == ST_DATA) begin
        bit_idx <= (state_q == ST_DATA) ? bit_idx + 1'b1 : '0;
      end
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl
//   Directed bench for uart_tx_ctrl. Two instances share stimulus: u_dut1 with one
//   stop bit and u_dut2 with two; sel2 picks which one the scoreboard observes.
//   A small bit mux and parity register stand in for the datapath so the
//   serial line value can be scored per cycle.
`timescale 1ns/1ps
module tb_uart_tx_ctrl;

  localparam int DW = 8;
  localparam int IW = 3;
  localparam int W  = 1 + 1 + 1 + 2 + IW + 1; // {ack, busy, pce, mux, idx, line}

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic          data_valid;
  logic [DW-1:0] p_data;
  logic          par_en;
  logic          par_typ;

  logic          ack1, busy1, pt1, pce1;
  logic [DW-1:0] dq1;
  logic [1:0]    mux1;
  logic [IW-1:0] idx1;
  logic [2:0]    st1;
  logic          ack2, busy2, pt2, pce2;
  logic [DW-1:0] dq2;
  logic [1:0]    mux2;
  logic [IW-1:0] idx2;
  logic [2:0]    st2;

  uart_tx_ctrl #(.DATA_WIDTH(DW), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .rst(rst), .data_valid(data_valid), .p_data(p_data),
    .par_en(par_en), .par_typ(par_typ), .data_ack(ack1), .busy(busy1),
    .data_q(dq1), .par_typ_q(pt1), .par_calc_en(pce1), .mux_sel(mux1),
    .bit_idx(idx1), .state_dbg(st1)
  );

  uart_tx_ctrl #(.DATA_WIDTH(DW), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .rst(rst), .data_valid(data_valid), .p_data(p_data),
    .par_en(par_en), .par_typ(par_typ), .data_ack(ack2), .busy(busy2),
    .data_q(dq2), .par_typ_q(pt2), .par_calc_en(pce2), .mux_sel(mux2),
    .bit_idx(idx2), .state_dbg(st2)
  );

  // Datapath stand-ins: parity registered at the end of START, then the bit mux.
  logic par1, par2;
  always @(posedge clk) begin
    if (pce1) par1 <= (^dq1) ^ pt1;
    if (pce2) par2 <= (^dq2) ^ pt2;
  end

  function automatic logic line_of(input logic [1:0] m, input logic [DW-1:0] d,
                                   input logic [IW-1:0] i, input logic p);
    logic l;
    l = 1'b1;
    case (m)
      2'b01:   l = 1'b0;
      2'b10:   l = d[i];
      2'b11:   l = p;
      default: l = 1'b1;
    endcase
    return l;
  endfunction

  logic         sel2;
  logic [W-1:0] vec1, vec2, obs_vec;
  logic         obs_busy, obs_ack;
  logic [1:0]   obs_mux;
  assign vec1     = {ack1, busy1, pce1, mux1, idx1, line_of(mux1, dq1, idx1, par1)};
  assign vec2     = {ack2, busy2, pce2, mux2, idx2, line_of(mux2, dq2, idx2, par2)};
  assign obs_vec  = sel2 ? vec2 : vec1;
  assign obs_busy = sel2 ? busy2 : busy1;
  assign obs_ack  = sel2 ? ack2 : ack1;
  assign obs_mux  = sel2 ? mux2 : mux1;

  // ---------------- scoreboard ----------------
  logic [W-1:0]  exp_q[$];
  logic [IW-1:0] model_idx;
  logic          active;
  int            item_no;
  int            n_checks;
  int            n_pass;
  int            n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic a, input logic b, input logic p,
                                      input logic [1:0] m, input logic [IW-1:0] i,
                                      input logic l);
    return {a, b, p, m, i, l};
  endfunction

  // Expected per-cycle outputs for one frame, starting with its START cycle.
  task automatic push_frame(input logic [DW-1:0] d, input logic pen, input logic typ,
                            input int nstop);
    exp_q.push_back(mk(1'b1, 1'b1, 1'b1, 2'b01, model_idx, 1'b0));
    for (int i = 0; i < DW; i++)
      exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 2'b10, IW'(i), d[i]));
    model_idx = IW'(DW - 1);
    if (pen)
      exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 2'b11, model_idx, (^d) ^ typ));
    for (int k = 0; k < nstop; k++)
      exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 2'b00, model_idx, 1'b1));
  endtask

  task automatic push_idle(input int n);
    for (int k = 0; k < n; k++)
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 2'b00, model_idx, 1'b1));
  endtask

  // Advance to the next falling edge and score one item once a frame is under way.
  task automatic tick();
    logic [W-1:0] e;
    @(negedge clk);
    if (exp_q.size() > 0 && (active || obs_busy)) begin
      e = exp_q.pop_front();
      check($sformatf("frame item %0d {ack,busy,pce,mux,idx,line}", item_no), 32'(obs_vec), 32'(e));
      item_no++;
      active = (exp_q.size() > 0);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_req(input logic [DW-1:0] d, input logic pen, input logic typ);
    tick();
    data_valid = 1'b1;
    p_data     = d;
    par_en     = pen;
    par_typ    = typ;
    tick();
    data_valid = 1'b0;
    p_data     = DW'($urandom_range(0, 255));
    par_en     = 1'($urandom_range(0, 1));
    par_typ    = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
    check($sformatf("%s drain", tag), 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    active = 1'b0;
  endtask

  task automatic wait_ack(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      tick();
      seen = obs_ack;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  task automatic check_reset(input string tag);
    check($sformatf("%s data_ack", tag), 32'(ack1), 32'd0);
    check($sformatf("%s busy", tag), 32'(busy1), 32'd0);
    check($sformatf("%s par_calc_en", tag), 32'(pce1), 32'd0);
    check($sformatf("%s mux_sel", tag), 32'(mux1), 32'd0);
    check($sformatf("%s bit_idx", tag), 32'(idx1), 32'd0);
    check($sformatf("%s data_q", tag), 32'(dq1), 32'd0);
    check($sformatf("%s par_typ_q", tag), 32'(pt1), 32'd0);
    check($sformatf("%s state", tag), 32'(st1), 32'd0);
    check($sformatf("%s dut2 busy", tag), 32'(busy2), 32'd0);
    check($sformatf("%s dut2 mux_sel", tag), 32'(mux2), 32'd0);
    check($sformatf("%s dut2 data_q", tag), 32'(dq2), 32'd0);
    check($sformatf("%s dut2 state", tag), 32'(st2), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    n_checks = 0; n_pass = 0; n_fail = 0; item_no = 0;
    active = 1'b0; sel2 = 1'b0; model_idx = '0;
    rst = 1'b1; data_valid = 1'b0; p_data = '0; par_en = 1'b0; par_typ = 1'b0;

    // Power-up reset, two cycles.
    tick(); tick();
    check_reset("por");
    rst = 1'b0;

    // Even parity, A5.
    push_frame(8'hA5, 1'b1, 1'b0, 1); push_idle(2);
    start_req(8'hA5, 1'b1, 1'b0);
    wait_drain("even A5");

    // No parity with odd type requested: no parity cycle, 10-cycle frame.
    push_frame(8'h3C, 1'b0, 1'b1, 1); push_idle(2);
    start_req(8'h3C, 1'b0, 1'b1);
    wait_drain("nopar 3C");

    // Back-to-back: data_valid held through two frames.
    push_frame(8'h01, 1'b1, 1'b0, 1); push_frame(8'hFF, 1'b1, 1'b0, 1); push_idle(2);
    tick();
    data_valid = 1'b1; p_data = 8'h01; par_en = 1'b1; par_typ = 1'b0;
    wait_ack("b2b first ack");
    p_data = 8'hFF;
    wait_ack("b2b second ack");
    data_valid = 1'b0;
    wait_drain("b2b");

    // Request while busy: ignored, original data still sent, line idle afterwards.
    push_frame(8'h96, 1'b1, 1'b0, 1); push_idle(3);
    start_req(8'h96, 1'b1, 1'b0);
    tick(); tick(); tick();
    data_valid = 1'b1; p_data = 8'h0F; par_en = 1'b0; par_typ = 1'b1;
    tick();
    data_valid = 1'b0;
    wait_drain("busy req");

    // Reset mid-DATA: aborts, outputs reset on the next edge, no resume.
    start_req(8'hC3, 1'b1, 1'b1);
    for (int i = 0; i < 20 && mux1 != 2'b10; i++) tick();
    check("mid reset reached DATA", 32'(mux1), 32'd2);
    tick(); tick();
    rst = 1'b1;
    tick();
    check_reset("mid reset");
    tick();
    rst = 1'b0;
    model_idx = '0;
    tick(); tick(); tick();
    check("after reset busy", 32'(busy1), 32'd0);
    check("after reset mux_sel", 32'(mux1), 32'd0);

    // Two stop bits, odd parity of 00 -> 1, 12-cycle frame (observed on u_dut2).
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    model_idx = '0;
    sel2 = 1'b1;
    push_frame(8'h00, 1'b1, 1'b1, 2); push_idle(2);
    start_req(8'h00, 1'b1, 1'b1);
    wait_drain("stop2 odd 00");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
